wb_sel_stage: RTL and testbench
===============================

// Module: wb_sel_stage
// PURPOSE
//   EX->WB pipeline stage of the NPC core: accepts one retiring result bundle per handshake and
//   aligns and extends load data. Selects the writeback value with the 5-way one-hot wb_sel.
//   Buffers selected results in a 2-entry skid queue. Drives register-file write port and retire handshake.
// PARAMETERS
//   XLEN     32  datapath width
//   RADDR_W  5   register index width
// PORTS
//   clk        in   1        clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        upstream bundle valid
//   in_ready   out  1        stage can accept (registered)
//   in_sel     in   5        one-hot wb select: [0]alu [1]mem [2]csr [3]pc4 [4]imm
//   in_alu/in_csr/in_pc4/in_imm  in  XLEN  candidate values
//   in_mem     in   XLEN     raw aligned memory word
//   in_mem_op  in   3        load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   in_addr_lo in   2        load byte address [1:0]
//   in_wen     in   1        instruction writes rd
//   in_rd      in   RADDR_W  destination register
//   out_valid  out  1        head entry valid
//   out_ready  in   1        consumer accepts head
//   rf_wen     out  1        = out_valid & out_ready & head.wen & (head.rd != 0)
//   rf_waddr   out  RADDR_W  head.rd
//   rf_wdata   out  XLEN     head.data
//   sel_err    out  1        sticky select-encoding error (see CONFIGURATION)
// BEHAVIOUR
//   - Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready.
//   - Data selection: OR of (mask(sel[i]) & cand_i). Zero-hot sel gives 0. Multi-hot gives the bitwise OR.
//   - Selection and alignment happen at enqueue; the entry stores {wen, rd, data}. Latency 1 cycle, in->out.
//   - Load alignment, mem candidate:
//       byte ops: lane = in_addr_lo.
//       half ops: lane = in_addr_lo[1] (bit 0 ignored).
//       LB/LH sign-extend. LBU/LHU zero-extend. LW passes in_mem.
//       Undefined mem_op passes in_mem.
//   - Occupancy FSM:
//       EMPTY: enq -> ONE.
//       ONE: enq&deq -> ONE; enq only -> TWO; deq only -> EMPTY.
//       TWO: deq -> ONE (no enq possible).
//   - FIFO order is strict; head is the oldest entry.
//   - in_ready = (state != TWO), registered from next-state. Asserts again the cycle after a dequeue from TWO.
//   - out_valid = (state != EMPTY). Head outputs are held stable while out_valid & !out_ready.
//   - rd==0 never produces rf_wen, even if wen=1.
//   - Reset (asynchronous, any time, mid-transfer included):
//       state=EMPTY, in_ready=1, out_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, sel_err=0.
//       Buffered entries are discarded.
// CONFIGURATION
//   WB_SEL_CHECK_EN defined: sel_err sets at an enqueue with in_wen=1 and popcount(in_sel)!=1.
//     It stays set until reset. Data path behaviour is unchanged.
//   WB_SEL_CHECK_EN undefined: sel_err is tied 0; no checker logic is built.
// STRUCTURE
//   Package wb_pkg:
//     WB_SEL_ALU..WB_SEL_IMM bit indices
//     LD_LB/LD_LH/LD_LW/LD_LBU/LD_LHU funct3 constants
//     wb_entry_t {wen, rd, data}
//     FSM state enum {EMPTY, ONE, TWO}
//   Sub-module wb_load_align (combinational: in_mem, mem_op, addr_lo -> extended word).
//   Top holds the FSM, two entry registers, head pointer and the one-hot select.
// TESTING
//   1 Reset, then sel=00001 alu=0x0000_1234 rd=5 wen=1, out_ready=1
//       -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x0000_1234.
//   2 sel=00010 LB in_mem=0x80FF_7F01 addr_lo=3 -> rf_wdata=0xFFFF_FF80.
//     Same word with LHU addr_lo=2 -> 0x0000_80FF.
//     LH addr_lo=1 -> 0x0000_7F01.
//   3 out_ready=0, push A,B -> in_ready=0 after the 2nd enqueue, head=A held stable.
//     Raise out_ready -> A then B retire in order; in_ready=1 the cycle after A retires.
//   4 State ONE with simultaneous enq and deq for 10 cycles
//       -> one retirement per cycle, in_ready stays 1, no entry lost or duplicated.
//   5 rd=0 wen=1 sel=01000 pc4=0x8000_0004 -> out_valid=1, rf_wen=0.
//     Also sel=00000 -> rf_wdata=0.
//   6 Assert rst_n=0 mid-cycle while in state TWO
//       -> out_valid=0 and in_ready=1 immediately.
//     With WB_SEL_CHECK_EN: sel=00011 wen=1 -> sel_err=1, held until reset.

Source files
------------

// File: rtl/wb_sel_stage_pkg.sv
// Shared constants and types for the EX->WB select stage: select bit indices,
// load funct3 codes, queue entry layout and occupancy states.
package wb_pkg;

   localparam int XLEN     = 32;
   localparam int RADDR_W  = 5;
   localparam int WB_SEL_W = 5;

   localparam int WB_SEL_ALU = 0;
   localparam int WB_SEL_MEM = 1;
   localparam int WB_SEL_CSR = 2;
   localparam int WB_SEL_PC4 = 3;
   localparam int WB_SEL_IMM = 4;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   typedef struct packed {
      logic               wen;
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } wb_state_e;

   // True when exactly one select line is raised.
   function automatic logic sel_onehot(input logic [WB_SEL_W-1:0] sel);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < WB_SEL_W; i++) begin
         cnt = cnt + {2'b00, sel[i]};
      end
      return (cnt == 3'd1);
   endfunction

endpackage

// File: rtl/wb_sel_stage_if.sv
// Upstream bundle, downstream retire handshake and register-file write port
// of the EX->WB select stage.
interface wb_sel_stage_if
   import wb_pkg::*;
();
   logic                in_valid;
   logic                in_ready;
   logic [WB_SEL_W-1:0] in_sel;
   logic [XLEN-1:0]     in_alu;
   logic [XLEN-1:0]     in_mem;
   logic [XLEN-1:0]     in_csr;
   logic [XLEN-1:0]     in_pc4;
   logic [XLEN-1:0]     in_imm;
   logic [2:0]          in_mem_op;
   logic [1:0]          in_addr_lo;
   logic                in_wen;
   logic [RADDR_W-1:0]  in_rd;
   logic                out_valid;
   logic                out_ready;
   logic                rf_wen;
   logic [RADDR_W-1:0]  rf_waddr;
   logic [XLEN-1:0]     rf_wdata;
   logic                sel_err;

   modport slave (
      input  in_valid, in_sel, in_alu, in_mem, in_csr, in_pc4, in_imm,
             in_mem_op, in_addr_lo, in_wen, in_rd, out_ready,
      output in_ready, out_valid, rf_wen, rf_waddr, rf_wdata, sel_err
   );

   modport master (
      output in_valid, in_sel, in_alu, in_mem, in_csr, in_pc4, in_imm,
             in_mem_op, in_addr_lo, in_wen, in_rd, out_ready,
      input  in_ready, out_valid, rf_wen, rf_waddr, rf_wdata, sel_err
   );
endinterface

// File: rtl/wb_sel_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of the memory word and
// sign- or zero-extends it according to the load funct3.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN_P = XLEN
) (
   input  logic [XLEN_P-1:0] mem,
   input  logic [2:0]        mem_op,
   input  logic [1:0]        addr_lo,
   output logic [XLEN_P-1:0] ext
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane extraction; half loads ignore addr_lo[0].
   always_comb begin
      byte_s = 8'(mem >> {addr_lo, 3'b000});
      half_s = addr_lo[1] ? mem[31:16] : mem[15:0];
   end

   // Extension by load type; unknown codes pass the raw word.
   always_comb begin
      case (mem_op)
         LD_LB:   ext = {{(XLEN_P-8){byte_s[7]}}, byte_s};
         LD_LH:   ext = {{(XLEN_P-16){half_s[15]}}, half_s};
         LD_LW:   ext = mem;
         LD_LBU:  ext = {{(XLEN_P-8){1'b0}}, byte_s};
         LD_LHU:  ext = {{(XLEN_P-16){1'b0}}, half_s};
         default: ext = mem;
      endcase
   end
endmodule

// File: rtl/wb_sel_stage.sv
// EX->WB select stage with a 2-entry skid queue feeding the register-file write port.
// Optional sticky select-encoding checker built when WB_SEL_CHECK_EN is defined.
module wb_sel_stage
   import wb_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   wb_sel_stage_if.slave bus
);
   localparam logic [1:0] S_EMPTY = 2'(ST_EMPTY);
   localparam logic [1:0] S_ONE   = 2'(ST_ONE);
   localparam logic [1:0] S_TWO   = 2'(ST_TWO);

   logic [1:0]      state_r;
   logic [1:0]      state_nxt_s;
   logic            hd_r;
   logic            in_ready_r;
   wb_entry_t       ent_r [2];
   wb_entry_t       head_s;
   wb_entry_t       new_ent_s;
   logic [XLEN-1:0] mem_ext_s;
   logic [XLEN-1:0] sel_data_s;
   logic            enq_s;
   logic            deq_s;
   logic            out_valid_s;
   logic            wr_idx_s;

   wb_load_align #(.XLEN_P(XLEN)) u_align (
      .mem     (bus.in_mem),
      .mem_op  (bus.in_mem_op),
      .addr_lo (bus.in_addr_lo),
      .ext     (mem_ext_s)
   );

   // AND-OR select: zero-hot yields 0, multi-hot yields the OR of candidates.
   always_comb begin
      sel_data_s = {XLEN{1'b0}};
      sel_data_s = sel_data_s | ({XLEN{bus.in_sel[WB_SEL_ALU]}} & bus.in_alu);
      sel_data_s = sel_data_s | ({XLEN{bus.in_sel[WB_SEL_MEM]}} & mem_ext_s);
      sel_data_s = sel_data_s | ({XLEN{bus.in_sel[WB_SEL_CSR]}} & bus.in_csr);
      sel_data_s = sel_data_s | ({XLEN{bus.in_sel[WB_SEL_PC4]}} & bus.in_pc4);
      sel_data_s = sel_data_s | ({XLEN{bus.in_sel[WB_SEL_IMM]}} & bus.in_imm);
   end

   assign new_ent_s   = '{wen: bus.in_wen, rd: bus.in_rd, data: sel_data_s};
   assign out_valid_s = (state_r != S_EMPTY);
   assign enq_s       = bus.in_valid & in_ready_r;
   assign deq_s       = out_valid_s & bus.out_ready;
   // An empty queue writes at the head slot, otherwise behind it.
   assign wr_idx_s    = (state_r == S_EMPTY) ? hd_r : ~hd_r;
   assign head_s      = ent_r[hd_r];

   // Occupancy next-state.
   always_comb begin
      case (state_r)
         S_EMPTY: state_nxt_s = enq_s ? S_ONE : S_EMPTY;
         S_ONE: begin
            if (enq_s && !deq_s) begin
               state_nxt_s = S_TWO;
            end else if (!enq_s && deq_s) begin
               state_nxt_s = S_EMPTY;
            end else begin
               state_nxt_s = S_ONE;
            end
         end
         S_TWO:   state_nxt_s = deq_s ? S_ONE : S_TWO;
         default: state_nxt_s = S_EMPTY;
      endcase
   end

   // State, head pointer and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_EMPTY;
         hd_r       <= 1'b0;
         in_ready_r <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         hd_r       <= deq_s ? ~hd_r : hd_r;
         in_ready_r <= (state_nxt_s != S_TWO);
      end
   end

   // Entry storage; reset clears contents so the write port reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_r[0] <= '0;
         ent_r[1] <= '0;
      end else if (enq_s) begin
         ent_r[wr_idx_s] <= new_ent_s;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_s;
   assign bus.rf_wen    = deq_s & head_s.wen & (|head_s.rd);
   assign bus.rf_waddr  = out_valid_s ? head_s.rd : {RADDR_W{1'b0}};
   assign bus.rf_wdata  = out_valid_s ? head_s.data : {XLEN{1'b0}};

`ifdef WB_SEL_CHECK_EN
   logic sel_err_r;

   // Sticky flag for a writing bundle whose select is not one-hot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_r <= 1'b0;
      end else if (enq_s && bus.in_wen && !sel_onehot(bus.in_sel)) begin
         sel_err_r <= 1'b1;
      end
   end

   assign bus.sel_err = sel_err_r;
`else
   assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_sel_stage.sv
// Randomized self-checking bench for wb_sel_stage against a queue-based reference model.
module tb_wb_sel_stage;
   import wb_pkg::*;

   typedef struct {
      bit        wen;
      bit [4:0]  rd;
      bit [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t q[$];
   bit   err_m = 1'b0;

   always #5 clk = ~clk;

   wb_sel_stage_if bus();

   wb_sel_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit [31:0] ref_load(input bit [31:0] mem, input bit [2:0] op, input bit [1:0] addr);
      bit [31:0] b;
      bit [31:0] h;
      b = (mem >> (int'(addr) * 8)) & 32'h0000_00FF;
      h = (mem >> ((int'(addr) / 2) * 16)) & 32'h0000_FFFF;
      case (op)
         3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return mem;
      endcase
   endfunction

   // One clock: apply inputs after a falling edge, check, then advance the model.
   task automatic drive_cycle(input bit v, input bit [4:0] sel, input bit [31:0] alu,
                              input bit [31:0] csr, input bit [31:0] pc4, input bit [31:0] imm,
                              input bit [31:0] mem, input bit [2:0] op, input bit [1:0] addr,
                              input bit wen, input bit [4:0] rd, input bit ordy);
      bit     enq;
      bit     deq;
      bit     exp_wen;
      exp_t   e;
      bus.in_valid   = v;
      bus.in_sel     = sel;
      bus.in_alu     = alu;
      bus.in_csr     = csr;
      bus.in_pc4     = pc4;
      bus.in_imm     = imm;
      bus.in_mem     = mem;
      bus.in_mem_op  = op;
      bus.in_addr_lo = addr;
      bus.in_wen     = wen;
      bus.in_rd      = rd;
      bus.out_ready  = ordy;
      #1;
      check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
      check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      exp_wen = (q.size() > 0) && ordy && q[0].wen && (q[0].rd != 5'd0);
      check_val("rf_wen", {31'd0, bus.rf_wen}, {31'd0, exp_wen});
      if (q.size() > 0) begin
         check_val("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, q[0].rd});
         check_val("rf_wdata", bus.rf_wdata, q[0].data);
      end
      check_val("sel_err", {31'd0, bus.sel_err}, {31'd0, err_m});
      enq = v && (q.size() < 2);
      deq = (q.size() > 0) && ordy;
      e.wen  = wen;
      e.rd   = rd;
      e.data = 32'd0;
      if (sel[0]) e.data = e.data | alu;
      if (sel[1]) e.data = e.data | ref_load(mem, op, addr);
      if (sel[2]) e.data = e.data | csr;
      if (sel[3]) e.data = e.data | pc4;
      if (sel[4]) e.data = e.data | imm;
      @(posedge clk);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
`ifdef WB_SEL_CHECK_EN
      if (enq && wen && ($countones(sel) != 1)) err_m = 1'b1;
`endif
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      drive_cycle(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b0, 5'd0, ordy);
   endtask

   task automatic reset_checks(input string tag);
      check_val({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check_val({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      check_val({tag, "_rf_wen"}, {31'd0, bus.rf_wen}, 32'd0);
      check_val({tag, "_rf_waddr"}, {27'd0, bus.rf_waddr}, 32'd0);
      check_val({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
      check_val({tag, "_sel_err"}, {31'd0, bus.sel_err}, 32'd0);
   endtask

   initial begin
      bit [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_sel = 5'd0;
      @(negedge clk);
      @(negedge clk);
      reset_checks("reset");
      rst_n = 1'b1;

      // Basic ALU writeback.
      drive_cycle(1'b1, 5'b00001, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd5, 1'b1);
      check_val("t1_rf_wen", {31'd0, bus.rf_wen}, 32'd1);
      check_val("t1_rf_waddr", {27'd0, bus.rf_waddr}, 32'd5);
      check_val("t1_rf_wdata", bus.rf_wdata, 32'h0000_1234);

      // Load alignment corners.
      drive_cycle(1'b1, 5'b00010, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80FF_7F01, 3'd0, 2'd3, 1'b1, 5'd6, 1'b1);
      check_val("t2_lb", bus.rf_wdata, 32'hFFFF_FF80);
      drive_cycle(1'b1, 5'b00010, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80FF_7F01, 3'd5, 2'd2, 1'b1, 5'd7, 1'b1);
      check_val("t2_lhu", bus.rf_wdata, 32'h0000_80FF);
      drive_cycle(1'b1, 5'b00010, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80FF_7F01, 3'd1, 2'd1, 1'b1, 5'd8, 1'b1);
      check_val("t2_lh", bus.rf_wdata, 32'h0000_7F01);
      idle(1'b1);

      // Back-pressure: fill both slots, hold, then drain in order.
      drive_cycle(1'b1, 5'b00001, 32'hAAAA_0001, 32'd0, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd10, 1'b0);
      drive_cycle(1'b1, 5'b00100, 32'd0, 32'hBBBB_0002, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd11, 1'b0);
      check_val("t3_full", {31'd0, bus.in_ready}, 32'd0);
      idle(1'b0);
      idle(1'b0);
      check_val("t3_head", bus.rf_wdata, 32'hAAAA_0001);
      idle(1'b1);
      check_val("t3_ready_back", {31'd0, bus.in_ready}, 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Streaming through a single slot.
      for (int i = 0; i < 11; i++) begin
         drive_cycle(1'b1, 5'b10000, 32'd0, 32'd0, 32'd0, 32'h0100_0000 + i, 32'd0, 3'd2, 2'd0,
                     1'b1, 5'(i + 1), 1'b1);
      end
      idle(1'b1);

      // rd=0 never writes; zero-hot select yields 0.
      drive_cycle(1'b1, 5'b01000, 32'd0, 32'd0, 32'h8000_0004, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd0, 1'b1);
      check_val("t5_valid", {31'd0, bus.out_valid}, 32'd1);
      check_val("t5_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
      drive_cycle(1'b1, 5'b00000, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 3'd2, 2'd0, 1'b0, 5'd9, 1'b1);
      check_val("t5_zero_sel", bus.rf_wdata, 32'd0);
      idle(1'b1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit [4:0] sel;
         sel = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
         drive_cycle($urandom_range(0, 3) != 0, sel, $urandom, $urandom, $urandom, $urandom, $urandom,
                     ops[$urandom_range(0, 7)], 2'($urandom), 1'($urandom), 5'($urandom),
                     $urandom_range(0, 2) != 0);
      end

      // Asynchronous reset while full.
      idle(1'b1);
      idle(1'b1);
      drive_cycle(1'b1, 5'b00001, 32'h1111_1111, 32'd0, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd1, 1'b0);
      drive_cycle(1'b1, 5'b00001, 32'h2222_2222, 32'd0, 32'd0, 32'd0, 32'd0, 3'd2, 2'd0, 1'b1, 5'd2, 1'b0);
      check_val("t6_full", {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks("t6_async");
      q.delete();
      err_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);

`ifdef WB_SEL_CHECK_EN
      drive_cycle(1'b1, 5'b00011, 32'h0000_00F0, 32'd0, 32'd0, 32'd0, 32'h0000_000F, 3'd2, 2'd0, 1'b1, 5'd3, 1'b1);
      check_val("t6_sel_err", {31'd0, bus.sel_err}, 32'd1);
      idle(1'b1);
      idle(1'b1);
      check_val("t6_sel_err_hold", {31'd0, bus.sel_err}, 32'd1);
      rst_n = 1'b0;
      #1;
      reset_checks("t6_err_reset");
      err_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
